// File: rtl/rr_grant_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// Drives a registered one-hot select, decoded from a registered grant index.
module rr_grant_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_idx,
  output logic       o_grant_valid,
  output logic       o_hold_expired
);

  localparam int unsigned REQ_W = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Last legal count value; a grantee still requesting here loses the grant.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_hold_expired;
  logic             r_grant_valid;
  logic [REQ_W-1:0] r_grant;

  logic [REQ_W-1:0] w_req_rot;
  logic [IDX_W-1:0] w_win_off;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_any;
  logic             w_own_req;
  logic             w_load;

  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_exp_nxt;
  logic             w_valid_nxt;
  logic [REQ_W-1:0] w_grant_nxt;

  // Rotate requests so bit 0 is the requester at the priority pointer.
  always_comb begin
    w_req_rot = i_req;
    case (r_ptr)
      2'd0:    w_req_rot = i_req;
      2'd1:    w_req_rot = {i_req[0],   i_req[3:1]};
      2'd2:    w_req_rot = {i_req[1:0], i_req[3:2]};
      2'd3:    w_req_rot = {i_req[2:0], i_req[3]};
      default: w_req_rot = i_req;
    endcase
  end

  // Lowest set bit of the rotated vector is the winner's offset from ptr.
  always_comb begin
    w_win_off = 2'd0;
    casez (w_req_rot)
      4'b???1: w_win_off = 2'd0;
      4'b??10: w_win_off = 2'd1;
      4'b?100: w_win_off = 2'd2;
      4'b1000: w_win_off = 2'd3;
      default: w_win_off = 2'd0;
    endcase
  end

  assign w_win_any = |i_req;
  assign w_win_idx = r_ptr + w_win_off;
  assign w_own_req = i_req[r_grant_idx];

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_grant_idx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_hold_cnt;
    w_exp_nxt   = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_win_any) begin
          w_load = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_own_req) begin
          if (r_hold_cnt < HOLD_LAST) begin
            w_cnt_nxt = r_hold_cnt + CNT_W'(1);
          end else begin
            w_exp_nxt = 1'b1;
            w_load    = 1'b1;
          end
        end else if (w_win_any) begin
          w_load = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Any new selection (fresh, hand-off or post-expiry) advances the pointer.
    if (w_load) begin
      w_state_nxt = S_GRANT;
      w_idx_nxt   = w_win_idx;
      w_ptr_nxt   = w_win_idx + IDX_W'(1);
      w_cnt_nxt   = '0;
    end

    w_valid_nxt = (w_state_nxt == S_GRANT);
    w_grant_nxt = w_valid_nxt ? (REQ_W'(1) << w_idx_nxt) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_grant_idx    <= '0;
      r_ptr          <= '0;
      r_hold_cnt     <= '0;
      r_hold_expired <= 1'b0;
      r_grant_valid  <= 1'b0;
      r_grant        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_grant_idx    <= w_idx_nxt;
      r_ptr          <= w_ptr_nxt;
      r_hold_cnt     <= w_cnt_nxt;
      r_hold_expired <= w_exp_nxt;
      r_grant_valid  <= w_valid_nxt;
      r_grant        <= w_grant_nxt;
    end
  end

  assign o_grant        = r_grant;
  assign o_grant_idx    = r_grant_idx;
  assign o_grant_valid  = r_grant_valid;
  assign o_hold_expired = r_hold_expired;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Scoreboard bench: four arbiters (MAX_HOLD 1,2,3,8) share one stimulus stream
// and are checked against a queue of expectations from a cycle-level model.
module tb_rr_grant_arbiter4;

  localparam int unsigned NI = 4;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       expd;
    logic       ci;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] g0, g1, g2, g3;
  logic [1:0] i0, i1, i2, i3;
  logic       v0, v1, v2, v3;
  logic       x0, x1, x2, x3;

  int total = 0;
  int bad   = 0;

  exp_t [NI-1:0] sbq[$];

  int m_busy[NI];
  int m_idx[NI];
  int m_ptr[NI];
  int m_held[NI];

  always #5 clk = ~clk;

  rr_grant_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) u_dut_h1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_grant(g0), .o_grant_idx(i0),
    .o_grant_valid(v0), .o_hold_expired(x0));
  rr_grant_arbiter4 #(.MAX_HOLD(2), .CNT_W(4)) u_dut_h2 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_grant(g1), .o_grant_idx(i1),
    .o_grant_valid(v1), .o_hold_expired(x1));
  rr_grant_arbiter4 #(.MAX_HOLD(3), .CNT_W(4)) u_dut_h3 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_grant(g2), .o_grant_idx(i2),
    .o_grant_valid(v2), .o_hold_expired(x2));
  rr_grant_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) u_dut_h8 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_grant(g3), .o_grant_idx(i3),
    .o_grant_valid(v3), .o_hold_expired(x3));

  function automatic int mh(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  // Reference: who owns the resource, for how many cycles, and where the scan starts.
  task automatic model(input int i, input logic r, input logic [3:0] rq, output exp_t e);
    bit pick;
    bit found;
    pick   = 1'b0;
    e      = '0;
    if (r) begin
      m_busy[i] = 0; m_idx[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
    end else if (m_busy[i] == 0) begin
      pick = (rq != 4'b0000);
    end else if (rq[m_idx[i]] && m_held[i] < mh(i)) begin
      m_held[i] = m_held[i] + 1;
    end else if (!rq[m_idx[i]]) begin
      if (rq != 4'b0000) pick = 1'b1;
      else m_busy[i] = 0;
    end else begin
      e.expd = 1'b1;
      pick   = 1'b1;
    end
    if (pick) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[i] + k) % 4;
        if (!found && rq[c]) begin
          found    = 1'b1;
          m_idx[i] = c;
        end
      end
      m_ptr[i]  = (m_idx[i] + 1) % 4;
      m_held[i] = 1;
      m_busy[i] = 1;
    end
    e.valid = (m_busy[i] != 0);
    e.grant = e.valid ? (4'b0001 << m_idx[i]) : 4'b0000;
    e.idx   = 2'(m_idx[i]);
    e.ci    = e.valid | r;
  endtask

  // Apply one cycle of stimulus and queue what each DUT must show after the edge.
  task automatic step(input logic r, input logic [3:0] rq);
    exp_t [NI-1:0] row;
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    for (int i = 0; i < NI; i++) begin
      model(i, r, rq, e);
      row[i] = e;
    end
    sbq.push_back(row);
  endtask

  task automatic hold(input logic r, input logic [3:0] rq, input int n);
    for (int k = 0; k < n; k++) step(r, rq);
  endtask

  task automatic chk(input string nm, input int inst, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s hold=%0d t=%0t got=%0h want=%0h", nm, mh(inst), $time, act, want);
    end
  endtask

  // Monitor: one output set per cycle, compared against the oldest expectation.
  initial begin
    exp_t [NI-1:0] row;
    logic [3:0] ag[NI];
    logic [1:0] ai[NI];
    logic       av[NI];
    logic       ax[NI];
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        row = sbq.pop_front();
        ag[0] = g0; ag[1] = g1; ag[2] = g2; ag[3] = g3;
        ai[0] = i0; ai[1] = i1; ai[2] = i2; ai[3] = i3;
        av[0] = v0; av[1] = v1; av[2] = v2; av[3] = v3;
        ax[0] = x0; ax[1] = x1; ax[2] = x2; ax[3] = x3;
        for (int i = 0; i < NI; i++) begin
          chk("grant", i, int'(ag[i]), int'(row[i].grant));
          chk("grant_valid", i, int'(av[i]), int'(row[i].valid));
          chk("hold_expired", i, int'(ax[i]), int'(row[i].expd));
          if (row[i].ci) chk("grant_idx", i, int'(ai[i]), int'(row[i].idx));
        end
      end
    end
  end

  initial begin
    logic       r;
    logic [3:0] rq;
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 0; m_idx[i] = 0; m_ptr[i] = 0; m_held[i] = 0;
    end

    // Reset held with all requests, then first grant goes to requester 0.
    hold(1'b1, 4'b1111, 3);
    step(1'b0, 4'b1111);
    hold(1'b0, 4'b0000, 2);
    // Single requester, released before any limit on the long-hold unit.
    hold(1'b0, 4'b0100, 5);
    hold(1'b0, 4'b0000, 2);
    // Full contention for rotation and expiry pulses.
    hold(1'b0, 4'b1111, 16);
    hold(1'b0, 4'b0000, 2);
    // Sole requester repeatedly re-granted after expiry.
    hold(1'b0, 4'b0010, 7);
    hold(1'b0, 4'b0000, 1);
    // Reset pointer, then release hand-off from requester 0.
    step(1'b1, 4'b0000);
    hold(1'b0, 4'b0001, 1);
    hold(1'b0, 4'b1100, 3);
    hold(1'b0, 4'b0000, 1);
    // Reset in the middle of contention.
    hold(1'b0, 4'b1111, 7);
    step(1'b1, 4'b1111);
    hold(1'b0, 4'b1111, 4);

    // Random phase: sticky requests with occasional flips, bursts and resets.
    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 15));
      if (sel < 4) rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
      else if (sel == 4) rq = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 99) == 0);
      step(r, rq);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 0, sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter4.md
# rr_grant_arbiter4

Round-robin arbiter that shares one 4-way resource among four requesters. It drives the resource's one-hot select from a registered 2-bit grant index, decoded 2-to-4. A hold counter bounds how long any requester keeps the grant. Only one clock domain is used. The block sits in front of the decoder-selected datapath and is the only source of its select lines.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one requester may hold a grant; legal range 1..2^CNT_W.
- CNT_W, 4: width of the hold counter.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  4  level request per requester; bit i = requester i.
- grant  out  4  one-hot grant, equal to decode(grant_idx) when grant_valid=1, else 4'b0000.
- grant_idx  out  2  index of the current grantee.
- grant_valid  out  1  a grant is active.
- hold_expired  out  1  one-cycle pulse: the grant was taken away by the MAX_HOLD limit.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: grant_idx owns the resource.
- Round-robin pointer ptr (2 bits) = priority start. On reset ptr=0. On every new grant, ptr = winner+1 mod 4.
- Winner selection: first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4. Selection is combinational on the current req; the result is registered.
- IDLE -> GRANT when any req bit is 1. Winner loaded, hold_cnt=0.
- GRANT, req[grant_idx]=1, hold_cnt < MAX_HOLD-1: stay; hold_cnt++.
- GRANT, req[grant_idx]=0 (release):
  - another req pending -> new winner granted at the same edge, no idle cycle;
  - none pending -> IDLE.
- GRANT, req[grant_idx]=1, hold_cnt = MAX_HOLD-1 (expiry):
  - hold_expired=1 for the next cycle;
  - a new winner is chosen from ptr, i.e. from grant_idx+1, so the current grantee can win again only if it is the sole requester;
  - re-grant or hand-off both reset hold_cnt=0.
- MAX_HOLD=1: every grant lasts exactly one cycle. Strict rotation among active requesters.
- grant is never multi-hot. A grant bit can only be 1 if the matching req was 1 at the selecting edge.
- req bits of non-grantees changing mid-grant have no effect until the next selection.

## Timing
- Reset values, at the first edge with rst=1:
  - grant=0000, grant_idx=00, grant_valid=0, hold_expired=0;
  - state=IDLE, ptr=0, hold_cnt=0.
- rst has priority over all transitions. rst asserted mid-grant clears the grant at the next edge. The first selection after reset starts from requester 0.
- Request-to-grant latency: req sampled at edge n, grant visible after edge n (1 cycle, registered).
- Release latency: req[grant_idx] low at edge n -> grant changes after edge n. The resource is never granted to a dropped requester for more than the cycle in which it drops.
- Hold bound: a continuously requesting grantee owns the resource for exactly MAX_HOLD cycles per grant.
- hold_expired: high exactly one cycle, concurrent with the first cycle of the follow-on grant.
- All outputs are registered. There is no combinational path from req to outputs.

## Test plan
- Reset: hold rst=1 with req=1111 for 3 cycles -> grant=0000, grant_valid=0, hold_expired=0 throughout. Release rst -> next cycle grant=0001.
- Single requester, MAX_HOLD=8: req=0100 for 5 cycles then 0000 -> grant=0100 for 5 cycles starting 1 cycle after req, then 0000. No hold_expired.
- Fairness, MAX_HOLD=2: req=1111 held for 16 cycles -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000, repeat. hold_expired pulses every 2 cycles.
- Sole requester expiry, MAX_HOLD=3: req=0010 held for 7 cycles -> grant stays 0010. hold_expired high on cycles 4 and 7 after first grant.
- Release hand-off: grant=0001 active, req goes 0001->1100 -> next cycle grant=0100 (scan from 1). Zero idle cycles, hold_cnt restarts.
- Reset mid-operation: during grant=1000 with req=1111, assert rst for 1 cycle -> grant=0000 that cycle. Next grant=0001, not 0001-after-1000 ordering.
